dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory (16-bit word address, 32-bit data).
- Memory timing: write commits on the posedge; read data is updated on the negedge while mem_read is high.
- Port 0 is the core load/store unit; port 1 is the auxiliary master (DMA or debug loader).
- Grants one access at a time, round-robin on contention, drives the memory control lines from registers, and returns read data with a one-cycle ack pulse.

Parameters:
ADDR_WIDTH, 16, memory word address width
DATA_WIDTH, 32, data width
COUNT_WIDTH, 16, width of grant counters (only with DMEM_ARB_STATS_EN)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 request, level
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  ADDR_WIDTH  port 0 address
wdata0  input  DATA_WIDTH  port 0 write data
ack0  output  1  port 0 completion pulse
rdata0  output  DATA_WIDTH  port 0 read data
req1, we1, addr1, wdata1, ack1, rdata1  (same as port 0, for port 1)
mem_address  output  ADDR_WIDTH  to memory address
mem_write_data  output  DATA_WIDTH  to memory write data
mem_write  output  1  to memory write strobe
mem_read  output  1  to memory read strobe
mem_read_data  input  DATA_WIDTH  from memory read data

Behaviour:
- Reset values: state=IDLE; all ack, mem_write, mem_read = 0; mem_address, mem_write_data, rdata0, rdata1 = 0; last_grant=1, so port 0 wins the first tie.
- All outputs are registered. No combinational path from req to any memory line.
- IDLE:
  - Sample req0/req1 at the posedge.
  - If neither is set, stay in IDLE.
  - If one is set, grant it.
  - If both are set, grant the port other than last_grant.
  - On grant: latch addr/we/wdata of the winner into mem_address, mem_write_data, mem_write=we, mem_read=~we; record the winner in last_grant and sel; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Memory samples mem_write at the closing posedge, or updates mem_read_data at the mid-cycle negedge.
  - At the closing posedge: clear mem_write/mem_read; assert ack[sel]=1; if read, rdata[sel] <= mem_read_data; go to RESP.
- RESP (1 cycle):
  - ack[sel] is high this cycle only.
  - All req inputs are ignored this cycle.
  - At the closing posedge: ack <= 0; go to IDLE.
- Latency and throughput: req sampled at edge k -> ack high between edges k+1 and k+2. Maximum throughput is one access per 3 cycles.
- Requester rules:
  - Hold req until ack is seen.
  - Deassert req at the edge where ack is sampled high.
  - A req still high in IDLE is a new access.
  - addr/we/wdata need only be valid at the grant edge.
- rdataN holds its last read value. Writes and the other port's accesses do not change it.
- No starvation: under continuous contention, grants alternate 0,1,0,1.
- ack0 and ack1 are never high together. mem_write and mem_read are never high together.
- Reset mid-operation: state goes to IDLE and outputs take their reset values at that edge; no ack is issued. If reset arrives at the ACCESS closing edge with a write, the memory still commits the write (mem_write was high at that edge). This is accepted and documented.
- Address is used unmodified, with no wrap logic. Width must equal the memory address width.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs grant_count0 and grant_count1 (COUNT_WIDTH each).
  - Each increments by 1 at the grant edge for its port.
  - Saturates at all-ones.
  - Cleared by reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Port 0 write addr=0x0010 data=0xDEADBEEF, then port 0 read 0x0010 -> write ack at k+1..k+2 with mem_write=1 for exactly one cycle; read ack0 with rdata0=0xDEADBEEF; rdata1 unchanged.
- req0 and req1 both rise at the same edge after reset, both reads -> port 0 granted first; port 1 granted at the next IDLE; ack0 then ack1, never overlapping; mem_read never overlaps mem_write.
- Both ports hold req continuously for 8 accesses -> grant order 0,1,0,1,0,1,0,1; each access spans 3 cycles.
- Port 1 write 0x00000005 to 0xFFFF, port 0 read 0xFFFF -> rdata0=0x00000005, confirming the full address range.
- Reset asserted during ACCESS of a read -> next cycle state is IDLE, no ack, all memory strobes 0; a fresh req0 afterwards completes normally.
- With DMEM_ARB_STATS_EN: 3 port 0 and 2 port 1 grants -> grant_count0=3, grant_count1=2; after reset both are 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer for the single-ported data memory; `define DMEM_ARB_STATS_EN adds per-port grant counters
module dmem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] grant_count0,
  output logic [COUNT_WIDTH-1:0] grant_count1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  // last_grant resets to 1 so port 0 wins the first tie
  logic last_grant;
  logic sel;
  logic grant_valid;
  logic grant_port;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state and grant decision; requests only matter in IDLE
  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_valid = 1'b1;
          if (req0 && req1) begin
            grant_port = ~last_grant;
          end else begin
            grant_port = req1;
          end
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // registered memory strobes, acks and read-data holding registers
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant     <= 1'b1;
      sel            <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel        <= grant_port;
            last_grant <= grant_port;
            if (grant_port) begin
              mem_address    <= addr1;
              mem_write_data <= wdata1;
              mem_write      <= we1;
              mem_read       <= ~we1;
            end else begin
              mem_address    <= addr0;
              mem_write_data <= wdata0;
              mem_write      <= we0;
              mem_read       <= ~we0;
            end
          end
        end
        ACCESS: begin
          // memory has committed the write or refreshed read data by now
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (sel) begin
            ack1 <= 1'b1;
            if (mem_read) rdata1 <= mem_read_data;
          end else begin
            ack0 <= 1'b1;
            if (mem_read) rdata0 <= mem_read_data;
          end
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // saturating per-port grant counters, bumped at the grant edge
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count0 <= '0;
      grant_count1 <= '0;
    end else if (grant_valid) begin
      if (!grant_port && (grant_count0 != '1)) grant_count0 <= grant_count0 + 1'b1;
      if (grant_port && (grant_count1 != '1)) grant_count1 <= grant_count1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write, mem_read;
  logic [31:0] mem_read_data = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_count0, grant_count1;
`endif

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  logic [31:0] mem [0:65535];

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_STATS_EN
    , .grant_count0(grant_count0), .grant_count1(grant_count1)
`endif
  );

  always #5 clock = ~clock;

  // memory: write commits on posedge, read data refreshed on negedge
  always @(posedge clock) begin
    if (mem_write) mem[mem_address] = mem_write_data;
  end

  always @(negedge clock) begin
    if (mem_read) mem_read_data = mem[mem_address];
  end

  // exclusivity monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (ack0 && ack1) overlap = overlap + 1;
      if (mem_write && mem_read) overlap = overlap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // one access from an idle arbiter: ack must appear two edges after the request is set
  task automatic do_access(input logic port, input logic w, input logic [15:0] a, input logic [31:0] d);
    int  lat;
    logic seen;
    if (port) begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      tick();
      lat++;
      seen = port ? ack1 : ack0;
    end
    chk($sformatf("latency_p%0d_addr%h", port, a), lat, 32'd2);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  int gport [0:7];
  int gcyc  [0:7];
  int gi;

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chkb("rst_ack0", ack0, 1'b0);
    chkb("rst_ack1", ack1, 1'b0);
    chkb("rst_mem_write", mem_write, 1'b0);
    chkb("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);

    // port 0 write with cycle-exact timing
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 32'hDEADBEEF;
    tick();
    chkb("wr_grant_mem_write", mem_write, 1'b1);
    chkb("wr_grant_mem_read", mem_read, 1'b0);
    chk("wr_grant_addr", 32'(mem_address), 32'h0010);
    chk("wr_grant_wdata", mem_write_data, 32'hDEADBEEF);
    chkb("wr_grant_ack0", ack0, 1'b0);
    tick();
    chkb("wr_ack0", ack0, 1'b1);
    chkb("wr_ack1", ack1, 1'b0);
    chkb("wr_strobe_one_cycle", mem_write, 1'b0);
    req0 = 1'b0;
    tick();
    chkb("wr_ack0_pulse", ack0, 1'b0);
    do_access(1'b0, 1'b0, 16'h0010, 32'h0);
    chk("rd0_after_wr", rdata0, 32'hDEADBEEF);
    chk("rd1_untouched", rdata1, 32'h0);

    // seed a second location through port 1
    do_access(1'b1, 1'b1, 16'h0030, 32'hCAFEF00D);

    // simultaneous reads right after reset: port 0 first
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
    tick();
    chkb("tie_grant_read", mem_read, 1'b1);
    chk("tie_grant_addr_p0", 32'(mem_address), 32'h0010);
    tick();
    chkb("tie_ack0", ack0, 1'b1);
    chkb("tie_ack1_low", ack1, 1'b0);
    chk("tie_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    tick();
    tick();
    chk("tie_grant_addr_p1", 32'(mem_address), 32'h0030);
    tick();
    chkb("tie_ack1", ack1, 1'b1);
    chkb("tie_ack0_low", ack0, 1'b0);
    chk("tie_rdata1", rdata1, 32'hCAFEF00D);
    req1 = 1'b0;
    tick();

    // continuous contention: eight grants alternating 0,1,... three cycles apart
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
    gi = 0;
    for (int c = 0; c < 40 && gi < 8; c++) begin
      tick();
      if (mem_read) begin
        gport[gi] = (mem_address == 16'h0030) ? 1 : 0;
        gcyc[gi]  = c;
        gi++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_grant_count", gi, 32'd8);
    for (int i = 0; i < gi; i++) begin
      chk($sformatf("rr_order_%0d", i), gport[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk($sformatf("rr_spacing_%0d", i), gcyc[i] - gcyc[i-1], 32'd3);
    end
    tick();
    tick();
    tick();
    chk("rr_rdata0", rdata0, 32'hDEADBEEF);
    chk("rr_rdata1", rdata1, 32'hCAFEF00D);

    // top of the address range
    do_access(1'b1, 1'b1, 16'hFFFF, 32'h00000005);
    do_access(1'b0, 1'b0, 16'hFFFF, 32'h0);
    chk("maxaddr_rdata0", rdata0, 32'h00000005);
    chk("maxaddr_rdata1_held", rdata1, 32'hCAFEF00D);

    // reset while a read is in ACCESS
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    tick();
    chkb("midrst_in_access", mem_read, 1'b1);
    reset = 1'b1;
    req0  = 1'b0;
    tick();
    chkb("midrst_ack0", ack0, 1'b0);
    chkb("midrst_mem_read", mem_read, 1'b0);
    chkb("midrst_mem_write", mem_write, 1'b0);
    chk("midrst_addr", 32'(mem_address), 32'h0);
    chk("midrst_rdata0", rdata0, 32'h0);
    reset = 1'b0;
    tick();
    chkb("midrst_no_late_ack", ack0, 1'b0);
    do_access(1'b0, 1'b0, 16'h0010, 32'h0);
    chk("midrst_recover_rdata0", rdata0, 32'hDEADBEEF);

`ifdef DMEM_ARB_STATS_EN
    do_reset();
    do_access(1'b0, 1'b0, 16'h0010, 32'h0);
    do_access(1'b1, 1'b0, 16'h0030, 32'h0);
    do_access(1'b0, 1'b0, 16'h0010, 32'h0);
    do_access(1'b1, 1'b0, 16'h0030, 32'h0);
    do_access(1'b0, 1'b0, 16'h0010, 32'h0);
    chk("stats_count0", 32'(grant_count0), 32'd3);
    chk("stats_count1", 32'(grant_count1), 32'd2);
    do_reset();
    chk("stats_count0_rst", 32'(grant_count0), 32'd0);
    chk("stats_count1_rst", 32'(grant_count1), 32'd0);
`endif

    chk("no_overlap", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
